genera_ceros: RTL and testbench

- Inverse of the team's serial zero counter: takes a zero count and serially builds a WIDTH-bit word containing exactly that many zeros, packed thermometer-style in the low bits.
- Produces one bit per clock, LSB first, on a registered serial output.
- Presents the finished word in parallel with a sticky done flag.
- Used as a stimulus/pattern source feeding the zero counter; loopback must return the original count.

---
 rtl/genera_ceros_if.sv | 23 ++
 rtl/genera_ceros.sv | 107 ++++++++++
 tb/tb_genera_ceros.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/genera_ceros_if.sv
// Handshake/data bundle between a pattern consumer (master) and genera_ceros (slave).
interface genera_ceros_if #(
   parameter int WIDTH   = 8,
   parameter int COUNT_W = 4
);
   logic               start;
   logic [COUNT_W-1:0] count;
   logic [WIDTH-1:0]   word;
   logic               bit_out;
   logic               bit_valid;
   logic               busy;
   logic               done;

   modport master (
      output start, count,
      input  word, bit_out, bit_valid, busy, done
   );

   modport slave (
      input  start, count,
      output word, bit_out, bit_valid, busy, done
   );
endinterface

// File: rtl/genera_ceros.sv
// Serially builds a WIDTH-bit word holding exactly cnt_lat zeros in its low bits,
// one bit per clock LSB first, then holds it with a sticky done flag.
module genera_ceros #(
   parameter int WIDTH   = 8,
   parameter int COUNT_W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   genera_ceros_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUILD, DONE} state_t;

   localparam logic [COUNT_W-1:0] LP_WIDTH = COUNT_W'(WIDTH);
   localparam logic [COUNT_W-1:0] LP_LAST  = COUNT_W'(WIDTH - 1);

   state_t             r_state;
   logic [COUNT_W-1:0] r_idx;
   logic [COUNT_W-1:0] r_cnt_lat;
   logic [WIDTH-1:0]   r_word;
   logic               r_bit_out;
   logic               r_bit_valid;
   logic               r_done;

   state_t             w_state;
   logic [COUNT_W-1:0] w_idx;
   logic [COUNT_W-1:0] w_cnt_lat;
   logic [WIDTH-1:0]   w_word;
   logic [WIDTH-1:0]   w_word_build;
   logic               w_bit_out;
   logic               w_bit_valid;
   logic               w_done;
   logic               w_bit;

   assign w_bit = (r_idx >= r_cnt_lat);

   // Per-bit write decode avoids indexing the word with an over-wide index.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_word_bit
         assign w_word_build[gi] = (r_idx == COUNT_W'(gi)) ? w_bit : r_word[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_cnt_lat   <= '0;
         r_word      <= '0;
         r_bit_out   <= 1'b0;
         r_bit_valid <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_idx       <= w_idx;
         r_cnt_lat   <= w_cnt_lat;
         r_word      <= w_word;
         r_bit_out   <= w_bit_out;
         r_bit_valid <= w_bit_valid;
         r_done      <= w_done;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_idx       = r_idx;
      w_cnt_lat   = r_cnt_lat;
      w_word      = r_word;
      w_bit_out   = r_bit_out;
      w_bit_valid = r_bit_valid;
      w_done      = r_done;

      // start wins in every state, so it also aborts a build in progress.
      if (bus.start) begin
         w_cnt_lat   = (bus.count > LP_WIDTH) ? LP_WIDTH : bus.count;
         w_idx       = '0;
         w_word      = '0;
         w_done      = 1'b0;
         w_bit_valid = 1'b0;
         w_state     = BUILD;
      end else begin
         case (r_state)
            BUILD: begin
               w_word      = w_word_build;
               w_bit_out   = w_bit;
               w_bit_valid = 1'b1;
               if (r_idx == LP_LAST) begin
                  w_idx   = '0;
                  w_state = DONE;
                  w_done  = 1'b1;
               end else begin
                  w_idx = r_idx + 1'b1;
               end
            end
            default: begin
               w_bit_valid = 1'b0;
            end
         endcase
      end
   end

   assign bus.word      = r_word;
   assign bus.bit_out   = r_bit_out;
   assign bus.bit_valid = r_bit_valid;
   assign bus.busy      = (r_state == BUILD);
   assign bus.done      = r_done;
endmodule

// File: tb/tb_genera_ceros.sv
// Directed bench for genera_ceros: table of counts with expected words, plus
// abort, mid-build reset and zero-counter loopback sequences.
module tb_genera_ceros;
   localparam int WIDTH   = 8;
   localparam int COUNT_W = 4;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   genera_ceros_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) bus ();

   genera_ceros #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [COUNT_W-1:0] count;
      logic [WIDTH-1:0]   exp_word;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pulse_start(input logic [COUNT_W-1:0] c);
      @(negedge clk);
      bus.start = 1'b1;
      bus.count = c;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.count = 4'hA;
   endtask

   // Start edge already taken; walk edges 1..WIDTH checking each bit and the done timing.
   task automatic run_build(input logic [WIDTH-1:0] exp_word, input string tag);
      int bit_err;
      int done_err;
      bit_err  = 0;
      done_err = 0;
      check({tag, " word_cleared"}, 32'(bus.word), 32'h0);
      check({tag, " busy_after_start"}, 32'(bus.busy), 32'h1);
      for (int k = 1; k <= WIDTH; k++) begin
         @(posedge clk);
         #1;
         if (bus.bit_valid !== 1'b1 || bus.bit_out !== exp_word[k-1]) bit_err++;
         if (k < WIDTH && (bus.done !== 1'b0 || bus.busy !== 1'b1)) done_err++;
      end
      check({tag, " bit_errors"}, 32'(bit_err), 32'h0);
      check({tag, " early_done_or_busy"}, 32'(done_err), 32'h0);
      check({tag, " word"}, 32'(bus.word), 32'(exp_word));
      check({tag, " done_at_edge_w"}, 32'(bus.done), 32'h1);
      check({tag, " busy_low"}, 32'(bus.busy), 32'h0);
      @(posedge clk);
      #1;
      check({tag, " bit_valid_drops"}, 32'(bus.bit_valid), 32'h0);
      $display("[TB] build %s word=0x%02h done=%0b", tag, bus.word, bus.done);
   endtask

   function automatic int zero_count(input logic [WIDTH-1:0] w);
      int z;
      z = 0;
      for (int i = 0; i < WIDTH; i++) if (w[i] == 1'b0) z++;
      return z;
   endfunction

   initial begin
      int done_seen;
      int idle_err;
      logic [WIDTH-1:0] exp_w;
      n_tests   = 0;
      n_fail    = 0;
      bus.start = 1'b0;
      bus.count = '0;
      rst_n     = 1'b0;

      vecs[0] = '{4'd3,  8'hF8};
      vecs[1] = '{4'd0,  8'hFF};
      vecs[2] = '{4'd8,  8'h00};
      vecs[3] = '{4'd12, 8'h00};
      vecs[4] = '{4'd1,  8'hFE};
      vecs[5] = '{4'd5,  8'hE0};
      vecs[6] = '{4'd7,  8'h80};

      #12;
      check("reset word", 32'(bus.word), 32'h0);
      check("reset flags", {28'h0, bus.bit_out, bus.bit_valid, bus.busy, bus.done}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle after release", {28'h0, bus.bit_out, bus.bit_valid, bus.busy, bus.done}, 32'h0);

      for (int v = 0; v < 7; v++) begin
         pulse_start(vecs[v].count);
         run_build(vecs[v].exp_word, $sformatf("count=%0d", vecs[v].count));
      end

      // Abort: count=2 for four edges, then restart with count=5.
      done_seen = 0;
      pulse_start(4'd2);
      repeat (4) begin
         @(posedge clk);
         #1;
         if (bus.done !== 1'b0) done_seen++;
      end
      check("abort partial word", 32'(bus.word), 32'h0C);
      pulse_start(4'd5);
      if (bus.done !== 1'b0) done_seen++;
      check("abort no done", 32'(done_seen), 32'h0);
      check("restart bit_valid low", 32'(bus.bit_valid), 32'h0);
      run_build(8'hE0, "restart count=5");

      // Asynchronous reset after edge 3 of a build.
      pulse_start(4'd3);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset word", 32'(bus.word), 32'h0);
      check("midreset flags", {28'h0, bus.bit_out, bus.bit_valid, bus.busy, bus.done}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_err = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (bus.busy !== 1'b0 || bus.bit_valid !== 1'b0 || bus.done !== 1'b0 || bus.word !== 8'h00)
            idle_err++;
      end
      check("stays idle after reset", 32'(idle_err), 32'h0);
      $display("[TB] midreset idle_errors=%0d", idle_err);

      // Loopback through a zero-counter model; done must stick for >20 cycles.
      for (int c = 0; c <= WIDTH; c++) begin
         exp_w = 8'hFF << c;
         pulse_start(COUNT_W'(c));
         repeat (WIDTH) @(posedge clk);
         #1;
         check($sformatf("loopback count=%0d", c), 32'(zero_count(bus.word)), 32'(c));
         check($sformatf("loopback word count=%0d", c), 32'(bus.word), 32'(exp_w));
         repeat (22) @(posedge clk);
         #1;
         check($sformatf("done sticky count=%0d", c), 32'(bus.done), 32'h1);
         $display("[TB] loopback count=%0d word=0x%02h zeros=%0d", c, bus.word, zero_count(bus.word));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
